// File: rtl/move_pkg.sv
// Shared types for the cursor seek controller: FSM states, per-axis step
// direction and the shortest-direction rule used on a wrapping coordinate ring.
package move_pkg;

  typedef enum logic [1:0] {IDLE, STEP, WAIT, DONE} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_INC, DIR_DEC} dir_t;

  // diff is (target - pos) mod 2^w, zero-extended; a half-way tie goes up.
  function automatic dir_t shortest_dir(input logic [31:0] diff, input int unsigned w);
    if (diff == 32'd0) return DIR_NONE;
    if (diff <= (32'd1 << (w - 1))) return DIR_INC;
    return DIR_DEC;
  endfunction

endpackage

// File: rtl/move_step_timer.sv
// Step pacing counter: loaded with STEP_CYCLES-1 on each step, counts down
// while enabled, and flags expiry on the last wait cycle.
module move_step_timer #(
  parameter int STEP_CYCLES = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(STEP_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset)                      count <= '0;
    else if (load)                   count <= CW'(STEP_CYCLES - 1);
    else if (en && count != '0)      count <= count - CW'(1);
  end

  assign expire = (count <= CW'(1));

endmodule

// File: rtl/move_seek.sv
// Cursor seek controller: walks a tracked position toward a captured target on
// a wrapping 2^W grid, one paced step at a time. Define MOVE_SEEK_DIAGONAL_EN
// to step both axes together while both still differ.
module move_seek
  import move_pkg::*;
#(
  parameter int W           = 2,
  parameter int STEP_CYCLES = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] target_x,
  input  logic [W-1:0] target_y,
  output logic         up,
  output logic         down,
  output logic         left,
  output logic         right,
  output logic [W-1:0] pos_x,
  output logic [W-1:0] pos_y,
  output logic         busy,
  output logic         done
);

  state_t       state, state_n;
  logic [W-1:0] tgt_x, tgt_y;
  logic [W-1:0] diff_x, diff_y;
  logic [W-1:0] px_n, py_n;
  dir_t         dir_x, dir_y, sx, sy;
  logic         accept, tmr_load, tmr_expire;

  assign diff_x = tgt_x - pos_x;
  assign diff_y = tgt_y - pos_y;
  assign dir_x  = shortest_dir(32'(diff_x), W);
  assign dir_y  = shortest_dir(32'(diff_y), W);

  assign start_ready = (state == IDLE);
  assign busy        = (state == STEP) || (state == WAIT);

  move_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (tmr_load),
    .en     (state == WAIT),
    .expire (tmr_expire)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    tmr_load = 1'b0;
    sx       = DIR_NONE;
    sy       = DIR_NONE;
    px_n     = pos_x;
    py_n     = pos_y;
    case (state)
      IDLE: begin
        if (start_valid) begin
          accept  = 1'b1;
          state_n = (target_x == pos_x && target_y == pos_y) ? DONE : STEP;
        end
      end
      STEP: begin
`ifdef MOVE_SEEK_DIAGONAL_EN
        sx = dir_x;
        sy = dir_y;
`else
        if (dir_x != DIR_NONE) sx = dir_x;
        else                   sy = dir_y;
`endif
        if (sx == DIR_INC)      px_n = pos_x + W'(1);
        else if (sx == DIR_DEC) px_n = pos_x - W'(1);
        if (sy == DIR_INC)      py_n = pos_y + W'(1);
        else if (sy == DIR_DEC) py_n = pos_y - W'(1);
        // Arrival is judged on the post-step position so DONE follows the last step directly.
        if (STEP_CYCLES == 1) begin
          state_n = (px_n == tgt_x && py_n == tgt_y) ? DONE : STEP;
        end else begin
          state_n  = WAIT;
          tmr_load = 1'b1;
        end
      end
      WAIT: begin
        if (tmr_expire) state_n = (pos_x == tgt_x && pos_y == tgt_y) ? DONE : STEP;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pos_x <= '0;
      pos_y <= '0;
      tgt_x <= '0;
      tgt_y <= '0;
      up    <= 1'b0;
      down  <= 1'b0;
      left  <= 1'b0;
      right <= 1'b0;
      done  <= 1'b0;
    end else begin
      pos_x <= px_n;
      pos_y <= py_n;
      right <= (sx == DIR_INC);
      left  <= (sx == DIR_DEC);
      down  <= (sy == DIR_INC);
      up    <= (sy == DIR_DEC);
      done  <= (state == DONE);
      if (accept) begin
        tgt_x <= target_x;
        tgt_y <= target_y;
      end
    end
  end

endmodule

// File: tb/tb_move_seek.sv
// Bench for move_seek: two instances (STEP_CYCLES 1 and 3) share stimulus and
// are compared cycle by cycle against a step-list model of the seek.
module tb_move_seek;

  localparam int W    = 2;
  localparam int SPAN = 1 << W;
  localparam int HALF = SPAN / 2;
  localparam logic [10:0] IDLE_V = 11'b100_0000_0000;

  logic clock, reset, start_valid;
  logic [W-1:0] target_x, target_y;
  logic rdy1, up1, down1, left1, right1, busy1, done1;
  logic rdy3, up3, down3, left3, right3, busy3, done3;
  logic [W-1:0] px1, py1, px3, py3;

  int checks = 0;
  int failures = 0;
  int mx, my;
  int sxq[$], syq[$];

  move_seek #(.W(W), .STEP_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .start_valid(start_valid), .start_ready(rdy1),
    .target_x(target_x), .target_y(target_y), .up(up1), .down(down1),
    .left(left1), .right(right1), .pos_x(px1), .pos_y(py1), .busy(busy1), .done(done1));

  move_seek #(.W(W), .STEP_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset), .start_valid(start_valid), .start_ready(rdy3),
    .target_x(target_x), .target_y(target_y), .up(up3), .down(down3),
    .left(left3), .right(right3), .pos_x(px3), .pos_y(py3), .busy(busy3), .done(done3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Ordered list of steps (x sign, y sign) the seek from (mx,my) must take.
  function automatic void build(input int tx, input int ty);
    int dx, dy, nx, ny, gx, gy, n;
    dx = ((tx - mx) % SPAN + SPAN) % SPAN;
    dy = ((ty - my) % SPAN + SPAN) % SPAN;
    nx = 0; gx = 0; ny = 0; gy = 0;
    if (dx != 0) begin if (dx <= HALF) begin nx = dx; gx = 1; end else begin nx = SPAN - dx; gx = -1; end end
    if (dy != 0) begin if (dy <= HALF) begin ny = dy; gy = 1; end else begin ny = SPAN - dy; gy = -1; end end
    sxq.delete(); syq.delete();
`ifdef MOVE_SEEK_DIAGONAL_EN
    n = (nx > ny) ? nx : ny;
    for (int i = 0; i < n; i++) begin
      sxq.push_back(i < nx ? gx : 0);
      syq.push_back(i < ny ? gy : 0);
    end
`else
    n = nx + ny;
    for (int i = 0; i < nx; i++) begin sxq.push_back(gx); syq.push_back(0); end
    for (int i = 0; i < ny; i++) begin sxq.push_back(0); syq.push_back(gy); end
`endif
  endfunction

  // Expected {ready,busy,done,up,down,left,right,pos_x,pos_y} in cycle c after accept.
  function automatic logic [10:0] expv(input int sc, input int c);
    int n, k, j, px, py;
    logic [3:0] st;
    n = sxq.size();
    k = (c < 1) ? 0 : ((c - 1) / sc + 1);
    if (k > n) k = n;
    px = mx; py = my; st = 4'b0;
    for (int i = 0; i < k; i++) begin px += sxq[i]; py += syq[i]; end
    px = (px % SPAN + SPAN) % SPAN;
    py = (py % SPAN + SPAN) % SPAN;
    if (c >= 1 && (c - 1) % sc == 0 && (c - 1) / sc < n) begin
      j = (c - 1) / sc;
      st = {syq[j] < 0, syq[j] > 0, sxq[j] < 0, sxq[j] > 0};
    end
    return {c >= n * sc + 1, c < n * sc, c == n * sc + 1, st, 2'(px), 2'(py)};
  endfunction

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", nm, act, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic [10:0] e1, input logic [10:0] e3);
    chk({tag, "/sc1"}, {rdy1, busy1, done1, up1, down1, left1, right1, px1, py1}, e1);
    chk({tag, "/sc3"}, {rdy3, busy3, done3, up3, down3, left3, right3, px3, py3}, e3);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start_valid = 1'b0;
    @(posedge clock); #1;
    chk_both("in_reset", IDLE_V, IDLE_V);
    reset = 1'b1;
    @(posedge clock); #1;
    chk_both("after_reset", IDLE_V, IDLE_V);
    mx = 0; my = 0;
  endtask

  // One seek observed on both instances; hold keeps start_valid high with junk targets.
  task automatic run_seek(input int tx, input int ty, input bit hold, output int seen);
    int n;
    build(tx, ty);
    n = sxq.size();
    seen = 0;
    target_x = W'(tx); target_y = W'(ty);
    start_valid = 1'b1;
    @(posedge clock); #1;
    for (int c = 0; c <= 3 * n + 1; c++) begin
      if (c > 0) begin @(posedge clock); #1; end
      chk_both($sformatf("seek(%0d,%0d)c%0d", tx, ty, c), expv(1, c), expv(3, c));
      if (up1 || down1 || left1 || right1) seen++;
      if (hold && c <= n) begin
        start_valid = 1'b1;
        target_x = W'($urandom_range(0, SPAN - 1));
        target_y = W'($urandom_range(0, SPAN - 1));
      end else begin
        start_valid = 1'b0;
      end
    end
    start_valid = 1'b0;
    mx = tx; my = ty;
  endtask

  typedef struct {
    bit rst;
    bit hold;
    int tx;
    int ty;
    int n_ser;
    int n_dia;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int seen, nexp;
    tbl[0] = '{1, 0, 1, 0, 1, 1};
    tbl[1] = '{1, 0, 3, 0, 1, 1};
    tbl[2] = '{1, 0, 2, 2, 4, 2};
    tbl[3] = '{1, 0, 2, 0, 2, 2};
    tbl[4] = '{0, 1, 1, 1, 2, 1};
    tbl[5] = '{0, 0, 1, 1, 0, 0};
    tbl[6] = '{0, 1, 1, 1, 0, 0};
    tbl[7] = '{0, 0, 3, 3, 4, 2};

    reset = 1'b0; start_valid = 1'b0; target_x = '0; target_y = '0;
    mx = 0; my = 0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rst) do_reset();
      run_seek(tbl[i].tx, tbl[i].ty, tbl[i].hold, seen);
`ifdef MOVE_SEEK_DIAGONAL_EN
      nexp = tbl[i].n_dia;
`else
      nexp = tbl[i].n_ser;
`endif
      checks++;
      if (seen != nexp) begin
        failures++;
        $display("FAIL step_count vec%0d actual=%0d expected=%0d", i, seen, nexp);
      end
    end

    // Reset in cycle 2 of the seek to (2,2): no more pulses, no done.
    do_reset();
    build(2, 2);
    target_x = 2'd2; target_y = 2'd2; start_valid = 1'b1;
    @(posedge clock); #1;
    start_valid = 1'b0;
    chk_both("abort_c0", expv(1, 0), expv(3, 0));
    @(posedge clock); #1;
    chk_both("abort_c1", expv(1, 1), expv(3, 1));
    reset = 1'b0;
    @(posedge clock); #1;
    chk_both("abort_in_reset", IDLE_V, IDLE_V);
    reset = 1'b1;
    mx = 0; my = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      chk_both($sformatf("abort_quiet%0d", c), IDLE_V, IDLE_V);
    end

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0) do_reset();
      run_seek(int'($urandom_range(0, SPAN - 1)), int'($urandom_range(0, SPAN - 1)),
               bit'($urandom_range(0, 1)), seen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_seek.md
MOVE_SEEK -- requirements
Module: move_seek

Interface
REQ-001 SHALL have parameter W, default 2, coordinate width in bits; position space is 0..2^W-1 per axis.
REQ-002 SHALL have parameter STEP_CYCLES, default 1, cycles per step (>=1).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous active-low reset (0 = reset, sampled on posedge clock).
REQ-005 SHALL have port start_valid  input  1  target request.
REQ-006 SHALL have port start_ready  output  1  high when request can be accepted.
REQ-007 SHALL have port target_x  input  W  requested x, captured on accept.
REQ-008 SHALL have port target_y  input  W  requested y, captured on accept.
REQ-009 SHALL have ports up, down, left, right  output  1 each  single-cycle step commands for the cursor mover.
REQ-010 SHALL have ports pos_x, pos_y  output  W each  internally tracked cursor position.
REQ-011 SHALL have port busy  output  1  seek in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse on arrival.

Function
REQ-013 SHALL implement states IDLE, STEP, WAIT, DONE; start_ready = (state==IDLE).
REQ-014 SHALL accept a request when start_valid && start_ready at a posedge; capture targets; go to STEP, or DONE if target equals pos.
REQ-015 SHALL compute per-axis diff = (target - pos) mod 2^W; diff 0: no move; 1..2^(W-1): increment (right/down); else decrement (left/up); half-way tie increments.
REQ-016 SHALL in STEP assert exactly one registered step output for one cycle, x axis before y axis, and update pos by +/-1 with wrap mod 2^W in the same edge.
REQ-017 SHALL after each step go to WAIT for STEP_CYCLES-1 cycles (skip WAIT if STEP_CYCLES==1), then STEP again or DONE when pos equals target.
REQ-018 SHALL assert done for exactly one cycle in DONE, then return to IDLE; busy high in STEP and WAIT only.
REQ-019 SHALL ignore start_valid while not IDLE; target inputs changing mid-seek have no effect.
REQ-020 SHALL, with STEP_CYCLES=1, issue first step in cycle 1 after accept, N steps in cycles 1..N, done in cycle N+1; target==pos gives done in cycle 1, no steps.
REQ-021 SHALL never assert up with down, or left with right.

Reset
REQ-022 SHALL on reset==0 force state IDLE, pos_x=pos_y=0, up=down=left=right=0, busy=0, done=0, pacing counter 0; start_ready=1 from the first non-reset cycle.
REQ-023 SHALL abort any seek on reset mid-operation with no further step pulses and no done.

Configuration
REQ-024 SHALL with macro MOVE_SEEK_DIAGONAL_EN defined step both axes in the same STEP cycle while both diffs are non-zero (e.g. right+down together); step count = max(|dx|,|dy|).
REQ-025 SHALL without MOVE_SEEK_DIAGONAL_EN step one axis per STEP cycle per REQ-016; step count = |dx|+|dy|.

Structure
REQ-026 SHALL place the state enum, direction encoding (NONE/INC/DEC) and shortest-direction function in package move_pkg.
REQ-027 SHALL implement pacing as sub-module move_step_timer (load STEP_CYCLES-1, count down, expire flag).

Verification
REQ-028 SHALL cover: W=2, STEP_CYCLES=1, pos (0,0), target (1,0) -> right in cycle 1, done in cycle 2, pos (1,0).
REQ-029 SHALL cover: pos (0,0), target (3,0) -> single left (wrap) in cycle 1, pos (3,0), done in cycle 2.
REQ-030 SHALL cover: pos (0,0), target (2,2) -> right,right,down,down in cycles 1-4, done in cycle 5; with MOVE_SEEK_DIAGONAL_EN right+down in cycles 1-2, done in cycle 3.
REQ-031 SHALL cover: STEP_CYCLES=3, target (2,0) -> right in cycles 1 and 4, done in cycle 7.
REQ-032 SHALL cover: start_valid held during busy -> start_ready 0, second target ignored; target==pos -> done in cycle 1, no steps.
REQ-033 SHALL cover: reset=0 in cycle 2 of a 4-step seek -> all outputs 0, pos (0,0), no done, start_ready 1 afterwards.
